vu_access_sequencer: RTL
========================

# vu_access_sequencer

Bus-side request generator for the KVAZ RAM-disk path, sitting between the synchronized ВУ bus edges and the SDRAM arbiter's VU port. It rebuilds the 16-bit CPU address from the multiplexed row/column ~ШАП bus and classifies each selected cycle as a write or read using the ЗПЗУ edge and the status byte. It then presents exactly one request per bus cycle to the arbiter through a valid/ack handshake.

## Interface
- `TIMEOUT_CYCLES`, default 64: cycles a pending request may wait for `req_ack`. Used only when `VU_ACCESS_TIMEOUT_EN` is defined. Range 2..255.
- `clk` in 1: system clock (24 MHz `clk_cpu`); all logic on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `negedge_ras_n`, `negedge_cas_n` in 1: one-cycle synchronized strobe edges.
- `clean_ras_n` in 1: synchronized RAS level.
- `shap_n` in 8: raw inverted multiplexed address bus.
- `posedge_strob_sost` in 1: status strobe edge.
- `status_d` in 8: data bus at the status strobe; bit 7 = MEMR.
- `negedge_zpzu_n` in 1: memory-write edge.
- `data_in` in 8: data bus, sampled on the write edge.
- `sel` in 1: page-select active; ~blk_n from the ramdisk control.
- `addr` out 16: reconstructed address.
- `addr_valid` out 1: address complete for the current RAS cycle.
- `req_valid` out 1: request pending to the arbiter.
- `req_write` out 1: 1 = write, 0 = read.
- `req_addr` out 16: request address.
- `req_data` out 8: write data.
- `req_ack` in 1: arbiter accepted the request.
- `overrun` out 1: one-cycle pulse when an event is dropped.
- `timeout` out 1: one-cycle pulse when a request is abandoned.

## Operation
- Address reconstruction:
  - On `negedge_ras_n`: `addr[7:0] <= ~shap_n`, `addr_valid <= 0`, and the per-cycle `issued` flag is cleared.
  - On `negedge_cas_n` while `clean_ras_n == 0`: `addr[15:8] <= ~shap_n`, `addr_valid <= 1`.
  - `addr_valid` clears when `clean_ras_n` goes high.
  - `negedge_cas_n` without RAS low is ignored.
- Status capture:
  - On `posedge_strob_sost`: `memrd_psw <= status_d[7]`.
  - `memrd_psw` clears when a read request is issued.
- Request FSM states: IDLE, RDWAIT, REQ.
  - IDLE, on `sel & negedge_zpzu_n & ~issued`: latch `req_addr = addr` and `req_data = data_in`, set `req_write = 1`, go to REQ. The write is accepted even if `addr_valid` is 0 (ЗПЗУ always follows CAS on this bus); `req_addr` takes the current `addr`.
  - IDLE, on `sel & memrd_psw & ~issued`:
    - if `addr_valid`: latch the address, set `req_write = 0`, go to REQ.
    - otherwise go to RDWAIT.
  - RDWAIT, on `addr_valid`: issue the read, go to REQ.
  - RDWAIT, if `sel` drops or `negedge_ras_n` arrives: back to IDLE with no request.
  - REQ: `req_valid = 1`; `req_addr`, `req_data` and `req_write` are held stable. On `req_ack` go to IDLE and set `issued`.
- Simultaneous write edge and read condition in IDLE: write wins; `memrd_psw` is cleared.
- Any qualifying write or read event while in REQ: dropped, `overrun` pulses for 1 cycle, state unchanged.
- Reset while in REQ: the request is withdrawn immediately (async); no ack is expected afterward.

## Timing
- Reset values: `addr = 0`, `addr_valid = 0`, `req_valid = 0`, `req_write = 0`, `req_addr = 0`, `req_data = 0`, `overrun = 0`, `timeout = 0`; FSM = IDLE; `memrd_psw = 0`; `issued = 0`.
- `addr_valid` rises 1 cycle after the `negedge_ras_n`/`negedge_cas_n` strobe cycle.
- Write: `req_valid` high in the cycle after the `negedge_zpzu_n` cycle.
- Read: `req_valid` high 1 cycle after `sel & memrd_psw & addr_valid` is first true.
- `req_valid` falls in the cycle after `req_ack` is sampled high. An ack in the first `req_valid` cycle is legal, giving a minimum 1-cycle handshake. `req_ack` while `req_valid` is 0 is ignored.
- Back-to-back: a new request can issue in the cycle after returning to IDLE, but only in a new RAS cycle.

## Configuration
- `VU_ACCESS_TIMEOUT_EN` defined:
  - An 8-bit counter runs while in REQ.
  - When it reaches `TIMEOUT_CYCLES - 1` without ack: `req_valid` drops, `timeout` pulses for 1 cycle, FSM goes to IDLE and `issued` is set.
- Undefined: no counter; REQ waits indefinitely; `timeout` is tied to 0.

## Test plan
- Write: RAS edge with `shap_n = 8'hCB`, then CAS edge with `shap_n = 8'h5F`; `sel = 1`; write edge with `data_in = 8'h3C` → `req_valid`, `req_write = 1`, `req_addr = 16'hA034`, `req_data = 8'h3C`; ack after 3 cycles → `req_valid` low the next cycle.
- Late-address read: `status_d = 8'h80` strobe with `sel = 1` before CAS → FSM in RDWAIT, no request. CAS with `shap_n = 8'hFE` → read request 1 cycle after `addr_valid`, `req_addr[15:8] = 8'h01`, `req_write = 0`.
- Overrun: hold `req_ack = 0`, issue a write, then fire a second write edge in the next RAS cycle → `overrun` is a single-cycle pulse; `req_addr` and `req_data` keep their first values.
- One-per-cycle: two write edges within the same RAS cycle, with the ack between them → exactly one request.
- Timeout, with `VU_ACCESS_TIMEOUT_EN` defined and `TIMEOUT_CYCLES = 8`: pending request, no ack → `req_valid` drops after 8 cycles and `timeout` pulses once. With the macro undefined, `req_valid` is still high after 100 cycles.
- Reset mid-REQ: assert `reset_n = 0` during REQ → all outputs reach their reset values immediately; after release, the first request needs a fresh RAS/CAS sequence.

Source files
------------

// File: rtl/vu_access_sequencer.sv
// vu_access_sequencer: rebuilds the VU bus address and issues one arbiter request per RAS cycle.
// Optional request timeout is enabled by defining VU_ACCESS_TIMEOUT_EN.
module vu_access_sequencer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        negedge_ras_n,
    input  logic        negedge_cas_n,
    input  logic        clean_ras_n,
    input  logic [7:0]  shap_n,
    input  logic        posedge_strob_sost,
    input  logic [7:0]  status_d,
    input  logic        negedge_zpzu_n,
    input  logic [7:0]  data_in,
    input  logic        sel,
    output logic [15:0] addr,
    output logic        addr_valid,
    output logic        req_valid,
    output logic        req_write,
    output logic [15:0] req_addr,
    output logic [7:0]  req_data,
    input  logic        req_ack,
    output logic        overrun,
    output logic        timeout
);

    typedef enum logic [1:0] {S_IDLE, S_RDWAIT, S_REQ} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_addr;
    logic        r_addr_valid;
    logic        r_memrd_psw;
    logic        r_issued;
    logic [15:0] r_req_addr;
    logic [7:0]  r_req_data;
    logic        r_req_write;
    logic        r_overrun;

    logic w_wr_evt;
    logic w_rd_evt;
    logic w_load;
    logic w_load_write;
    logic w_psw_clr;
    logic w_drop;
    logic w_done;
    logic w_to_hit;
    logic w_unused_status;

    assign w_unused_status = ^status_d[6:0];

    assign w_wr_evt = sel & negedge_zpzu_n & ~r_issued;
    assign w_rd_evt = sel & r_memrd_psw & ~r_issued;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr       <= '0;
            r_addr_valid <= 1'b0;
        end else begin
            if (clean_ras_n)
                r_addr_valid <= 1'b0;
            if (negedge_ras_n) begin
                r_addr[7:0]  <= ~shap_n;
                r_addr_valid <= 1'b0;
            end else if (negedge_cas_n && !clean_ras_n) begin
                r_addr[15:8] <= ~shap_n;
                r_addr_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_memrd_psw <= 1'b0;
            r_issued    <= 1'b0;
        end else begin
            if (posedge_strob_sost)
                r_memrd_psw <= status_d[7];
            else if (w_psw_clr)
                r_memrd_psw <= 1'b0;
            // A fresh RAS edge opens a new bus cycle, so it outranks a same-cycle completion.
            if (negedge_ras_n)
                r_issued <= 1'b0;
            else if (w_done)
                r_issued <= 1'b1;
        end
    end

`ifdef VU_ACCESS_TIMEOUT_EN
    logic [7:0] r_to_cnt;
    logic       r_timeout;

    assign w_to_hit = (r_to_cnt == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_to_cnt  <= (r_state == S_REQ && w_next == S_REQ) ? r_to_cnt + 8'd1 : 8'd0;
            r_timeout <= (r_state == S_REQ) && !req_ack && w_to_hit;
        end
    end

    assign timeout = r_timeout;
`else
    logic [7:0] w_unused_timeout;

    assign w_unused_timeout = 8'(TIMEOUT_CYCLES);
    assign w_to_hit         = 1'b0;
    assign timeout          = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // NOTE: every signal gets a default before the case so no latches are inferred.
    always_comb begin
        w_next       = r_state;
        w_load       = 1'b0;
        w_load_write = 1'b0;
        w_psw_clr    = 1'b0;
        w_drop       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_wr_evt) begin
                    w_next       = S_REQ;
                    w_load       = 1'b1;
                    w_load_write = 1'b1;
                    w_psw_clr    = 1'b1;
                end else if (w_rd_evt) begin
                    if (r_addr_valid) begin
                        w_next    = S_REQ;
                        w_load    = 1'b1;
                        w_psw_clr = 1'b1;
                    end else begin
                        w_next = S_RDWAIT;
                    end
                end
            end
            S_RDWAIT: begin
                // An abandoned read also forgets its stale status so it cannot fire in a later cycle.
                if (!sel || negedge_ras_n) begin
                    w_next    = S_IDLE;
                    w_psw_clr = 1'b1;
                end else if (w_wr_evt) begin
                    w_next       = S_REQ;
                    w_load       = 1'b1;
                    w_load_write = 1'b1;
                    w_psw_clr    = 1'b1;
                end else if (r_addr_valid) begin
                    w_next    = S_REQ;
                    w_load    = 1'b1;
                    w_psw_clr = 1'b1;
                end
            end
            S_REQ: begin
                if (w_wr_evt || w_rd_evt) begin
                    w_drop    = 1'b1;
                    w_psw_clr = 1'b1;
                end
                if (req_ack || w_to_hit) begin
                    w_next = S_IDLE;
                    w_done = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_req_addr  <= '0;
            r_req_data  <= '0;
            r_req_write <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_overrun <= w_drop;
            if (w_load) begin
                r_req_addr  <= r_addr;
                r_req_write <= w_load_write;
                if (w_load_write)
                    r_req_data <= data_in;
            end
        end
    end

    assign addr       = r_addr;
    assign addr_valid = r_addr_valid;
    assign req_valid  = (r_state == S_REQ);
    assign req_write  = r_req_write;
    assign req_addr   = r_req_addr;
    assign req_data   = r_req_data;
    assign overrun    = r_overrun;

endmodule
